// File: rtl/restore_painter.sv
// ---------------------------------------------------------------------------
// restore_painter
//   Takes undo/redo restore events (x, y, colour, brush size), queues them in a
//   small circular FIFO, and replays each one to the framebuffer pixel-write
//   port as a square brush stamp. Each stamp pixel goes out as one valid/ready
//   transfer. Pixels that fall off the canvas are clipped: each clipped pixel
//   costs one cycle with wr_valid low.
//
// Ports
//   clk, rst        clock and asynchronous active-high reset
//   restore_valid   one-cycle strobe qualifying x_in/y_in/color_in/brush_sz
//   clear_ovf       one-cycle pulse that clears the sticky overflow flag
//   wr_valid/ready  pixel write handshake (wr_valid is a flop output)
//   wr_x/wr_y/...   pixel being written
//   busy            queue non-empty or stamp in progress
//   overflow        sticky flag: a restore event was dropped
//   fifo_level      number of queued events
// ---------------------------------------------------------------------------
module restore_painter #(
   parameter int FIFO_DEPTH = 4,
   parameter int X_MAX      = 159,
   parameter int Y_MAX      = 119
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       restore_valid,
   input  logic [7:0] x_in,
   input  logic [7:0] y_in,
   input  logic [2:0] color_in,
   input  logic [1:0] brush_sz,
   input  logic       clear_ovf,
   output logic       wr_valid,
   input  logic       wr_ready,
   output logic [7:0] wr_x,
   output logic [7:0] wr_y,
   output logic [2:0] wr_color,
   output logic       busy,
   output logic       overflow,
   output logic [2:0] fifo_level
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int DW = 21;
   localparam logic [CW-1:0] LP_FULL  = CW'(FIFO_DEPTH);
   localparam logic [8:0]    LP_X_MAX = 9'(X_MAX);
   localparam logic [8:0]    LP_Y_MAX = 9'(Y_MAX);

   // START is the single cycle after a pop in which the first stamp pixel is
   // evaluated and loaded into the output registers.
   typedef enum logic [1:0] {S_IDLE, S_START, S_PAINT} state_t;

   // ---------------- event queue ----------------
   logic [DW-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;

   // ---------------- stamp engine ----------------
   state_t     r_state, w_state_next;
   logic [7:0] r_ax, w_ax_next;
   logic [7:0] r_ay, w_ay_next;
   logic [2:0] r_col, w_col_next;
   logic [1:0] r_side, w_side_next;      // side length minus 1
   logic [1:0] r_dx, w_dx_next;
   logic [1:0] r_dy, w_dy_next;
   logic       r_wr_valid, w_wr_valid_next;
   logic [7:0] r_wr_x, w_wr_x_next;
   logic [7:0] r_wr_y, w_wr_y_next;
   logic [2:0] r_wr_color, w_wr_color_next;

   logic          w_empty, w_full, w_pop, w_push, w_drop;
   logic [DW-1:0] w_head;
   logic          w_last_col, w_last, w_step, w_in_range;
   logic [1:0]    w_adv_dx, w_adv_dy, w_tgt_dx, w_tgt_dy;
   logic [8:0]    w_px, w_py;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == LP_FULL);
   assign w_pop   = (r_state == S_IDLE) && !w_empty;
   // A full queue still takes a new event when the head leaves the same cycle.
   assign w_push  = restore_valid && (!w_full || w_pop);
   assign w_drop  = restore_valid && !w_push;
   assign w_head  = r_mem[r_rd_ptr];

   // Raster advance: dx first, then dy.
   assign w_last_col = (r_dx == r_side);
   assign w_last     = w_last_col && (r_dy == r_side);
   assign w_adv_dx   = w_last_col ? 2'd0 : r_dx + 2'd1;
   assign w_adv_dy   = w_last_col ? r_dy + 2'd1 : r_dy;

   // Pixel to present next: the first pixel from START, the next one in PAINT.
   assign w_tgt_dx   = (r_state == S_PAINT) ? w_adv_dx : 2'd0;
   assign w_tgt_dy   = (r_state == S_PAINT) ? w_adv_dy : 2'd0;
   // 9-bit sums so a stamp near x=255 clips instead of wrapping to x=0.
   assign w_px       = {1'b0, r_ax} + {7'd0, w_tgt_dx};
   assign w_py       = {1'b0, r_ay} + {7'd0, w_tgt_dy};
   assign w_in_range = (w_px <= LP_X_MAX) && (w_py <= LP_Y_MAX);

   // Current pixel is finished on a transfer, or immediately if it was clipped.
   assign w_step = !r_wr_valid || wr_ready;

   always_comb begin
      w_state_next    = r_state;
      w_ax_next       = r_ax;
      w_ay_next       = r_ay;
      w_col_next      = r_col;
      w_side_next     = r_side;
      w_dx_next       = r_dx;
      w_dy_next       = r_dy;
      w_wr_valid_next = r_wr_valid;
      w_wr_x_next     = r_wr_x;
      w_wr_y_next     = r_wr_y;
      w_wr_color_next = r_wr_color;
      case (r_state)
         S_IDLE: begin
            w_wr_valid_next = 1'b0;
            if (w_pop) begin
               {w_ax_next, w_ay_next, w_col_next, w_side_next} = w_head;
               w_dx_next    = 2'd0;
               w_dy_next    = 2'd0;
               w_state_next = S_START;
            end
         end
         S_START: begin
            w_wr_valid_next = w_in_range;
            if (w_in_range) begin
               w_wr_x_next     = w_px[7:0];
               w_wr_y_next     = w_py[7:0];
               w_wr_color_next = r_col;
            end
            w_state_next = S_PAINT;
         end
         S_PAINT: begin
            if (w_step) begin
               if (w_last) begin
                  w_wr_valid_next = 1'b0;
                  w_state_next    = S_IDLE;
               end else begin
                  w_dx_next       = w_adv_dx;
                  w_dy_next       = w_adv_dy;
                  w_wr_valid_next = w_in_range;
                  if (w_in_range) begin
                     w_wr_x_next     = w_px[7:0];
                     w_wr_y_next     = w_py[7:0];
                     w_wr_color_next = r_col;
                  end
               end
            end
         end
         default: begin
            w_wr_valid_next = 1'b0;
            w_state_next    = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_ax       <= '0;
         r_ay       <= '0;
         r_col      <= '0;
         r_side     <= '0;
         r_dx       <= '0;
         r_dy       <= '0;
         r_wr_valid <= 1'b0;
         r_wr_x     <= '0;
         r_wr_y     <= '0;
         r_wr_color <= '0;
      end else begin
         r_state    <= w_state_next;
         r_ax       <= w_ax_next;
         r_ay       <= w_ay_next;
         r_col      <= w_col_next;
         r_side     <= w_side_next;
         r_dx       <= w_dx_next;
         r_dy       <= w_dy_next;
         r_wr_valid <= w_wr_valid_next;
         r_wr_x     <= w_wr_x_next;
         r_wr_y     <= w_wr_y_next;
         r_wr_color <= w_wr_color_next;
      end
   end

   // Queue pointers, level and sticky overflow (a drop wins over clear_ovf).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_drop)
            r_overflow <= 1'b1;
         else if (clear_ovf)
            r_overflow <= 1'b0;
      end
   end

   // Queue storage has no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= {x_in, y_in, color_in, brush_sz};
   end

   assign wr_valid   = r_wr_valid;
   assign wr_x       = r_wr_x;
   assign wr_y       = r_wr_y;
   assign wr_color   = r_wr_color;
   assign busy       = (r_state != S_IDLE) || !w_empty;
   assign overflow   = r_overflow;
   assign fifo_level = 3'(r_count);

endmodule

// File: tb/tb_restore_painter.sv
// ---------------------------------------------------------------------------
// tb_restore_painter
//   Directed scenarios followed by a randomized run. Expected pixel writes are
//   generated from each accepted event by enumerating the brush square and
//   dropping off-canvas pixels; observed writes are collected from the
//   handshake and compared in order.
// ---------------------------------------------------------------------------
module tb_restore_painter;

   logic       clk = 1'b0;
   logic       rst;
   logic       restore_valid;
   logic [7:0] x_in;
   logic [7:0] y_in;
   logic [2:0] color_in;
   logic [1:0] brush_sz;
   logic       clear_ovf;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] wr_x;
   logic [7:0] wr_y;
   logic [2:0] wr_color;
   logic       busy;
   logic       overflow;
   logic [2:0] fifo_level;

   restore_painter #(.FIFO_DEPTH(4), .X_MAX(159), .Y_MAX(119)) dut (
      .clk(clk), .rst(rst), .restore_valid(restore_valid),
      .x_in(x_in), .y_in(y_in), .color_in(color_in), .brush_sz(brush_sz),
      .clear_ovf(clear_ovf), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .busy(busy),
      .overflow(overflow), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int rdy_mode = 0;           // 0 hold, 1 alternate, 2 random
   logic [18:0] exp_q[$];
   logic [18:0] got_q[$];
   logic        prev_stall = 1'b0;
   logic [18:0] prev_pix = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: enumerate the square in raster order, keep on-canvas pixels.
   function automatic void stamp(input int x, input int y, input int c, input int b);
      for (int dy = 0; dy <= b; dy++)
         for (int dx = 0; dx <= b; dx++)
            if (x + dx <= 159 && y + dy <= 119)
               exp_q.push_back({8'(x + dx), 8'(y + dy), 3'(c)});
   endfunction

   // Sampled mid-cycle: inputs are stable until the next rising edge, so
   // valid && ready here is exactly a transfer at that edge.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", 32'(wr_valid), 32'd1);
            check("hold_pix", 32'({wr_x, wr_y, wr_color}), 32'(prev_pix));
         end
         if (wr_valid && wr_ready)
            got_q.push_back({wr_x, wr_y, wr_color});
         prev_stall <= wr_valid && !wr_ready;
         prev_pix   <= {wr_x, wr_y, wr_color};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      case (rdy_mode)
         1: wr_ready = ~wr_ready;
         2: wr_ready = 1'($urandom_range(0, 1));
         default: ;
      endcase
   endtask

   task automatic issue(input int x, input int y, input int c, input int b);
      x_in = 8'(x); y_in = 8'(y); color_in = 3'(c); brush_sz = 2'(b);
      restore_valid = 1'b1;
      tick();
      restore_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy === 1'b1 && n < 3000) begin
         tick();
         n++;
      end
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic compare_writes(input string tag);
      int n;
      check({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check({tag, "_pix"}, 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b1; restore_valid = 1'b0; x_in = '0; y_in = '0; color_in = '0;
      brush_sz = '0; clear_ovf = 1'b0; wr_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_wr_valid", 32'(wr_valid), 32'd0);
      check("rst_wr_x", 32'(wr_x), 32'd0);
      check("rst_wr_y", 32'(wr_y), 32'd0);
      check("rst_wr_color", 32'(wr_color), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      rst = 1'b0;
      tick();

      // 1: single pixel, exact latency
      stamp(10, 20, 5, 0);
      issue(10, 20, 5, 0);
      check("t1_level_n", 32'(fifo_level), 32'd1);
      check("t1_valid_n", 32'(wr_valid), 32'd0);
      tick();
      check("t1_valid_n1", 32'(wr_valid), 32'd0);
      check("t1_busy_n1", 32'(busy), 32'd1);
      tick();
      check("t1_valid_n2", 32'(wr_valid), 32'd1);
      check("t1_x", 32'(wr_x), 32'd10);
      check("t1_y", 32'(wr_y), 32'd20);
      check("t1_color", 32'(wr_color), 32'd5);
      tick();
      check("t1_valid_n3", 32'(wr_valid), 32'd0);
      check("t1_busy_n3", 32'(busy), 32'd0);
      compare_writes("t1");

      // 2: 2x2 stamp with alternating ready
      rdy_mode = 1;
      stamp(5, 5, 3, 1);
      issue(5, 5, 3, 1);
      wait_idle("t2");
      compare_writes("t2");
      rdy_mode = 0; wr_ready = 1'b1;

      // 3: 4x4 stamp at the bottom-right corner
      stamp(158, 119, 1, 3);
      issue(158, 119, 1, 3);
      wait_idle("t3");
      compare_writes("t3");

      // 4: six strobes with the writer stalled
      wr_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i < 5) stamp(i * 20 + 1, i * 10, i, 0);
         issue(i * 20 + 1, i * 10, i, 0);
      end
      check("t4_overflow", 32'(overflow), 32'd1);
      check("t4_level", 32'(fifo_level), 32'd4);
      check("t4_stalled", 32'(wr_valid), 32'd1);
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      check("t4_ovf_clr", 32'(overflow), 32'd0);
      check("t4_level2", 32'(fifo_level), 32'd4);

      // 6: push into a full queue on the cycle it pops
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
      stamp(77, 33, 6, 0);
      issue(77, 33, 6, 0);
      check("t6_overflow", 32'(overflow), 32'd0);
      check("t6_level", 32'(fifo_level), 32'd4);
      wr_ready = 1'b1;
      wait_idle("t6");
      compare_writes("t46");

      // 5: reset mid-stamp with two events queued
      wr_ready = 1'b0;
      issue(30, 30, 2, 1);
      issue(40, 40, 3, 1);
      issue(50, 50, 4, 1);
      check("t5_valid_pre", 32'(wr_valid), 32'd1);
      check("t5_level_pre", 32'(fifo_level), 32'd2);
      rst = 1'b1;
      #1;
      check("t5_valid_rst", 32'(wr_valid), 32'd0);
      check("t5_busy_rst", 32'(busy), 32'd0);
      check("t5_level_rst", 32'(fifo_level), 32'd0);
      tick();
      rst = 1'b0;
      wr_ready = 1'b1;
      repeat (20) tick();
      check("t5_busy_post", 32'(busy), 32'd0);
      compare_writes("t5");

      // Randomized events, gaps and backpressure
      rdy_mode = 2;
      for (int i = 0; i < 40; i++) begin
         int gap, g, rx, ry, rc, rb;
         gap = $urandom_range(0, 3);
         repeat (gap) tick();
         g = 0;
         while (fifo_level >= 3 && g < 1000) begin
            tick();
            g++;
         end
         rx = $urandom_range(0, 255);
         ry = $urandom_range(0, 255);
         if ($urandom_range(0, 1) == 1) begin
            rx = $urandom_range(150, 165);
            ry = $urandom_range(110, 125);
         end
         rc = $urandom_range(0, 7);
         rb = $urandom_range(0, 3);
         stamp(rx, ry, rc, rb);
         issue(rx, ry, rc, rb);
      end
      wait_idle("rnd");
      compare_writes("rnd");
      check("rnd_overflow", 32'(overflow), 32'd0);
      rdy_mode = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
